// File: rtl/instruction_sequencer.sv
// Program-memory sequencer: streams 16-bit opcodes to a downstream core under a
// ready handshake and consumes class-10 control words (NOP/JUMP/GLOBAL LOAD/HALT) locally.
module instruction_sequencer #(
    parameter int BIT_WIDTH  = 8,
    parameter int PROG_DEPTH = 32,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [AW-1:0]             prog_waddr,
    input  logic [15:0]               prog_wdata,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      ready,
    output logic [15:0]               opcode,
    output logic                      execute,
    output logic [16*BIT_WIDTH-1:0]   global_registers_out,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           pc_q, pc_d, pc_inc;
    logic [15:0]             opcode_q, opcode_d;
    logic                    execute_q, execute_d;
    logic                    done_q, done_d;
    logic [16*BIT_WIDTH-1:0] gregs_q, gregs_d;
    logic [15:0]             mem [PROG_DEPTH];
    logic [15:0]             instr;
    logic [BIT_WIDTH-1:0]    load_val;

    assign instr    = mem[pc_q];
    assign pc_inc   = (pc_q == AW'(PROG_DEPTH - 1)) ? '0 : pc_q + 1'b1;
    assign load_val = BIT_WIDTH'(instr[7:0]);

    // Program memory is deliberately outside the reset domain so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            mem[prog_waddr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            execute_q <= 1'b0;
            done_q    <= 1'b0;
            gregs_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            execute_q <= execute_d;
            done_q    <= done_d;
            gregs_q   <= gregs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN:   if (ready && (instr[15:12] == 4'b1011)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Abort outranks everything; opcode only updates on a consumed (ready) RUN cycle.
    always_comb begin
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        execute_d = 1'b0;
        done_d    = 1'b0;
        gregs_d   = gregs_q;
        if (abort) begin
            pc_d = '0;
        end else if (state_q == S_IDLE) begin
            if (start) pc_d = '0;
        end else if (ready) begin
            opcode_d = instr;
            if (instr[15:14] != 2'b10) begin
                execute_d = 1'b1;
                pc_d      = pc_inc;
            end else begin
                case (instr[13:12])
                    2'b00: pc_d = pc_inc;
                    2'b01: pc_d = instr[AW-1:0];
                    2'b10: begin
                        gregs_d[int'(instr[11:8]) * BIT_WIDTH +: BIT_WIDTH] = load_val;
                        pc_d = pc_inc;
                    end
                    default: begin
                        done_d = 1'b1;
                        pc_d   = '0;
                    end
                endcase
            end
        end
    end

    assign opcode               = opcode_q;
    assign execute              = execute_q;
    assign done                 = done_q;
    assign busy                 = (state_q == S_RUN);
    assign global_registers_out = gregs_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_instruction_sequencer;

    localparam int BW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic           clk        = 1'b0;
    logic           rst        = 1'b1;
    logic           prog_we    = 1'b0;
    logic [AW-1:0]  prog_waddr = '0;
    logic [15:0]    prog_wdata = '0;
    logic           start      = 1'b0;
    logic           abort      = 1'b0;
    logic           ready      = 1'b0;
    logic [15:0]    opcode;
    logic           execute;
    logic           busy;
    logic           done;
    logic [16*BW-1:0] global_registers_out;

    int total = 0;
    int bad   = 0;

    instruction_sequencer #(
        .BIT_WIDTH  (BW),
        .PROG_DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .prog_we              (prog_we),
        .prog_waddr           (prog_waddr),
        .prog_wdata           (prog_wdata),
        .start                (start),
        .abort                (abort),
        .ready                (ready),
        .opcode               (opcode),
        .execute              (execute),
        .global_registers_out (global_registers_out),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: program as an array, pc as a plain integer modulo DEPTH.
    logic [15:0] m_mem [DEPTH];
    bit          m_run  = 1'b0;
    int          m_pc   = 0;
    logic [15:0] m_op   = '0;
    bit          m_exec = 1'b0;
    bit          m_done = 1'b0;
    logic [BW-1:0] m_g [16];

    task model_step();
        logic [15:0] ins;
        if (rst) begin
            m_run  = 1'b0;
            m_pc   = 0;
            m_op   = '0;
            m_exec = 1'b0;
            m_done = 1'b0;
            for (int i = 0; i < 16; i++) m_g[i] = '0;
        end else begin
            ins    = m_mem[m_pc[AW-1:0]];
            m_exec = 1'b0;
            m_done = 1'b0;
            if (prog_we && !m_run) m_mem[prog_waddr] = prog_wdata;
            if (abort) begin
                m_run = 1'b0;
                m_pc  = 0;
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1'b1;
                    m_pc  = 0;
                end
            end else if (ready) begin
                m_op = ins;
                if (ins[15:14] != 2'b10) begin
                    m_exec = 1'b1;
                    m_pc   = (m_pc + 1) % DEPTH;
                end else if (ins[13:12] == 2'b00) begin
                    m_pc = (m_pc + 1) % DEPTH;
                end else if (ins[13:12] == 2'b01) begin
                    m_pc = int'(ins) % DEPTH;
                end else if (ins[13:12] == 2'b10) begin
                    m_g[ins[11:8]] = ins[7:0];
                    m_pc = (m_pc + 1) % DEPTH;
                end else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_pc   = 0;
                end
            end
        end
    endtask

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task compare_model();
        logic [16*BW-1:0]      g_flat;
        logic [16+3+16*BW-1:0] exp_v;
        logic [16+3+16*BW-1:0] act_v;
        for (int i = 0; i < 16; i++) g_flat[i*BW +: BW] = m_g[i];
        exp_v = {m_op, m_exec, m_run, m_done, g_flat};
        act_v = {opcode, execute, busy, done, global_registers_out};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL model_cmp got=%h exp=%h at %0t", act_v, exp_v, $time);
        end
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task write_word(input int a, input logic [15:0] d);
        prog_we    = 1'b1;
        prog_waddr = AW'(a);
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    function automatic logic [BW-1:0] greg(input int y);
        return global_registers_out[y*BW +: BW];
    endfunction

    initial begin
        logic [15:0] exp_q [$];
        logic [15:0] w [DEPTH];
        logic [15:0] rerun_op [5];
        bit          rerun_ex [5];
        bit          pat [6];
        int          ex_cnt;
        int          dn_cnt;

        for (int i = 0; i < 16; i++) m_g[i] = '0;

        // Reset
        tick();
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_execute", 32'(execute), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_gregs", 32'(global_registers_out == '0), 32'h1);
        rst = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) write_word(i, 16'h8000);

        // Basic run: two opcodes then HALT
        write_word(0, 16'h0105);
        write_word(1, 16'h4000);
        write_word(2, 16'hB000);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t034_busy_start", 32'(busy), 32'h1);
        chk("t034_exec_start", 32'(execute), 32'h0);
        tick();
        chk("t034_op0", 32'(opcode), 32'h0105);
        chk("t034_ex0", 32'(execute), 32'h1);
        tick();
        chk("t034_op1", 32'(opcode), 32'h4000);
        chk("t034_ex1", 32'(execute), 32'h1);
        tick();
        chk("t034_ex_halt", 32'(execute), 32'h0);
        chk("t034_done", 32'(done), 32'h1);
        chk("t034_busy_end", 32'(busy), 32'h0);
        tick();
        chk("t034_done_once", 32'(done), 32'h0);

        // Global load
        write_word(0, 16'hA2A5);
        write_word(1, 16'hB000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t035_greg2", 32'(greg(2)), 32'hA5);
        chk("t035_ex", 32'(execute), 32'h0);
        tick();
        chk("t035_done", 32'(done), 32'h1);
        chk("t035_ex_halt", 32'(execute), 32'h0);
        tick();

        // JUMP loop then abort
        write_word(0, 16'h4000);
        write_word(1, 16'h9000);
        start = 1'b1;
        tick();
        start = 1'b0;
        ex_cnt = 0;
        dn_cnt = 0;
        repeat (10) begin
            tick();
            if (execute) ex_cnt++;
            if (done) dn_cnt++;
        end
        chk("t036_exec_count", 32'(ex_cnt), 32'd5);
        chk("t036_no_done", 32'(dn_cnt), 32'd0);
        chk("t036_busy_loop", 32'(busy), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t036_busy_abort", 32'(busy), 32'h0);
        chk("t036_done_abort", 32'(done), 32'h0);
        tick();
        chk("t036_done_after", 32'(done), 32'h0);

        // Ready stalls
        write_word(0, 16'h1111);
        write_word(1, 16'h2222);
        write_word(2, 16'h3333);
        write_word(3, 16'hB000);
        exp_q = {16'h1111, 16'h2222, 16'h3333};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ready = pat[i];
            tick();
            if (!pat[i]) chk("t037_stall_exec", 32'(execute), 32'h0);
            if (execute) begin
                if (exp_q.size() == 0) chk("t037_extra_exec", 32'h1, 32'h0);
                else chk("t037_order", 32'(opcode), 32'(exp_q.pop_front()));
            end
        end
        chk("t037_all_seen", 32'(exp_q.size()), 32'd0);
        chk("t037_done", 32'(done), 32'h1);
        ready = 1'b1;
        tick();

        // Asynchronous reset mid-run, then identical re-run
        write_word(0, 16'hA2A5);
        write_word(1, 16'h4000);
        write_word(2, 16'h4001);
        write_word(3, 16'h4002);
        write_word(4, 16'hB000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t038_greg2_pre", 32'(greg(2)), 32'hA5);
        tick();
        chk("t038_op_pre", 32'(opcode), 32'h4000);
        #2 rst = 1'b1;
        #1;
        chk("t038_async_opcode", 32'(opcode), 32'h0);
        chk("t038_async_exec", 32'(execute), 32'h0);
        chk("t038_async_busy", 32'(busy), 32'h0);
        chk("t038_async_gregs", 32'(global_registers_out == '0), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("t038_no_resume", 32'(busy), 32'h0);
        rerun_op = '{16'hA2A5, 16'h4000, 16'h4001, 16'h4002, 16'hB000};
        rerun_ex = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t038_rerun_op", 32'(opcode), 32'(rerun_op[i]));
            chk("t038_rerun_ex", 32'(execute), 32'(rerun_ex[i]));
        end
        chk("t038_rerun_done", 32'(done), 32'h1);
        chk("t038_rerun_greg2", 32'(greg(2)), 32'hA5);
        tick();

        // Full program without HALT: wrap, and writes during RUN ignored
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = 16'($urandom);
            if (w[i][15:14] == 2'b10) w[i][14] = 1'b1;
            write_word(i, w[i]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ex_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                prog_we    = 1'b1;
                prog_waddr = AW'(3);
                prog_wdata = 16'hB000;
            end
            tick();
            prog_we = 1'b0;
            if (execute) ex_cnt++;
            if (c == 32) chk("t039_last_word", 32'(opcode), 32'(w[DEPTH-1]));
            if (c == 33) chk("t039_wrap", 32'(opcode), 32'(w[0]));
            if (c == 36) chk("t039_ignored_write", 32'(opcode), 32'(w[3]));
        end
        chk("t039_exec_count", 32'(ex_cnt), 32'd40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t039_busy_abort", 32'(busy), 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            ready      = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 15) == 0);
            abort      = ($urandom_range(0, 40) == 0);
            prog_we    = ($urandom_range(0, 5) == 0);
            prog_waddr = AW'($urandom_range(0, DEPTH - 1));
            prog_wdata = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        start   = 1'b0;
        prog_we = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
